pc_sequencer: RTL and testbench

//  Next-PC controller for the 5-stage MIPS32 fetch stage. Selects the next fetch

---
 rtl/pc_seq_pkg.sv | 19 +
 rtl/pc_target_mux.sv | 41 ++++
 rtl/pc_sequencer.sv | 158 +++++++++++++++
 tb/tb_pc_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the MIPS32 next-PC sequencer.
// Exception support is enabled by defining PC_SEQ_EXC_EN.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT
  } seq_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_4180;
  localparam logic [31:0] PC_INCR          = 32'd4;

  function automatic logic [31:0] next_seq(input logic [31:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Priority select of the redirect target: (eret >) jr > jmp > br_taken.
// The eret leg exists only when PC_SEQ_EXC_EN is defined.
module pc_target_mux
  import pc_seq_pkg::*;
(
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
`ifdef PC_SEQ_EXC_EN
  input  logic        eret,
  input  logic [31:0] epc,
`endif
  output logic        any,
  output logic [31:0] tgt
);

  always_comb begin
    any = 1'b0;
    tgt = br_target;
`ifdef PC_SEQ_EXC_EN
    if (eret) begin
      any = 1'b1;
      tgt = epc;
    end else
`endif
    if (jr) begin
      any = 1'b1;
      tgt = jr_target;
    end else if (jmp) begin
      any = 1'b1;
      tgt = jmp_target;
    end else if (br_taken) begin
      any = 1'b1;
      tgt = br_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: boot, stalls, imem waits, buffered redirects.
// Define PC_SEQ_EXC_EN to add exc_req/eret inputs and the epc register.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR
`ifdef PC_SEQ_EXC_EN
  ,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        imem_ready,
`ifdef PC_SEQ_EXC_EN
  input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] epc,
`endif
  output logic        imem_req,
  output logic [31:0] npc,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush
);

  seq_state_e  state, state_nxt;
  logic        pend_vld;
  logic [31:0] pend_tgt;
  logic        any_redir, redir;
  logic [31:0] tgt, seq;
  logic        cap_pend, clr_pend;
`ifdef PC_SEQ_EXC_EN
  logic        take_exc;
`endif

  pc_target_mux u_mux (
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .jr         (jr),
    .jr_target  (jr_target),
`ifdef PC_SEQ_EXC_EN
    .eret       (eret),
    .epc        (epc),
`endif
    .any        (any_redir),
    .tgt        (tgt)
  );

  assign redir = !stall && any_redir;
  assign seq   = next_seq(pc);

  // Outputs are Mealy so a redirect reaches npc in the cycle it resolves;
  // the async reset also forces them so nothing fetches while reset is low.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    npc        = seq;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    cap_pend   = 1'b0;
    clr_pend   = 1'b0;
`ifdef PC_SEQ_EXC_EN
    take_exc   = 1'b0;
`endif
    if (!reset) begin
      npc        = RESET_VECTOR;
      ifid_flush = 1'b1;
    end else begin
      case (state)
        BOOT: begin
          pc_en      = 1'b1;
          npc        = RESET_VECTOR;
          ifid_flush = 1'b1;
          state_nxt  = RUN;
        end
        RUN: begin
          imem_req = 1'b1;
          if (!stall) begin
            ifid_en = 1'b1;
            if (imem_ready) begin
              pc_en = 1'b1;
              npc   = redir ? tgt : seq;
            end else begin
              ifid_flush = 1'b1;
              cap_pend   = redir;
              state_nxt  = WAIT;
            end
          end
        end
        WAIT: begin
          imem_req = 1'b1;
          if (!stall) begin
            ifid_en = 1'b1;
            if (imem_ready) begin
              pc_en     = 1'b1;
              npc       = pend_vld ? pend_tgt : seq;
              clr_pend  = 1'b1;
              state_nxt = RUN;
            end else begin
              ifid_flush = 1'b1;
            end
          end
        end
        default: state_nxt = BOOT;
      endcase
`ifdef PC_SEQ_EXC_EN
      if (exc_req && state != BOOT) begin
        take_exc   = 1'b1;
        npc        = EXC_VECTOR;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        cap_pend   = 1'b0;
        clr_pend   = 1'b1;
        state_nxt  = RUN;
      end
`endif
    end
  end

  // State, the redirect buffered across an imem wait, and the exception PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      pend_vld <= 1'b0;
      pend_tgt <= '0;
`ifdef PC_SEQ_EXC_EN
      epc      <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (clr_pend) begin
        pend_vld <= 1'b0;
      end else if (cap_pend) begin
        pend_vld <= 1'b1;
        pend_tgt <= tgt;
      end
`ifdef PC_SEQ_EXC_EN
      if (take_exc) begin
        epc <= pc;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer (exception steps when PC_SEQ_EXC_EN is defined).
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam logic [31:0] RV = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] npc;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
`ifdef PC_SEQ_EXC_EN
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
`endif

  typedef struct {
    string       tag;
    logic [31:0] npc;
    bit          chk_npc;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        imem_req;
    logic [31:0] epc;
    bit          chk_epc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .jr         (jr),
    .jr_target  (jr_target),
    .imem_ready (imem_ready),
`ifdef PC_SEQ_EXC_EN
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
`endif
    .imem_req   (imem_req),
    .npc        (npc),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .ifid_flush (ifid_flush)
  );

  function automatic exp_t mk(input string tag, input logic [31:0] n, input bit cn,
                              input logic pe, input logic ie, input logic fl,
                              input logic rq);
    exp_t e;
    e.tag = tag; e.npc = n; e.chk_npc = cn; e.pc_en = pe; e.ifid_en = ie;
    e.ifid_flush = fl; e.imem_req = rq; e.epc = '0; e.chk_epc = 1'b0;
    return e;
  endfunction

  task automatic idle();
    stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; jr = 1'b0;
    br_target = '0; jmp_target = '0; jr_target = '0;
`ifdef PC_SEQ_EXC_EN
    exc_req = 1'b0; eret = 1'b0;
`endif
  endtask

  task automatic checkOutput();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (e.chk_npc)
        assert (npc === e.npc) else begin
          miscompares++;
          $error("[TB] FAIL %s npc: observed %h expected %h", e.tag, npc, e.npc);
        end
      assert (pc_en === e.pc_en) else begin
        miscompares++;
        $error("[TB] FAIL %s pc_en: observed %b expected %b", e.tag, pc_en, e.pc_en);
      end
      assert (ifid_en === e.ifid_en) else begin
        miscompares++;
        $error("[TB] FAIL %s ifid_en: observed %b expected %b", e.tag, ifid_en, e.ifid_en);
      end
      assert (ifid_flush === e.ifid_flush) else begin
        miscompares++;
        $error("[TB] FAIL %s ifid_flush: observed %b expected %b", e.tag, ifid_flush,
               e.ifid_flush);
      end
      assert (imem_req === e.imem_req) else begin
        miscompares++;
        $error("[TB] FAIL %s imem_req: observed %b expected %b", e.tag, imem_req, e.imem_req);
      end
`ifdef PC_SEQ_EXC_EN
      if (e.chk_epc)
        assert (epc === e.epc) else begin
          miscompares++;
          $error("[TB] FAIL %s epc: observed %h expected %h", e.tag, epc, e.epc);
        end
`endif
    end
  endtask

  // Inputs are already driven; queue the expectation, compare mid-cycle, advance.
  task automatic applyStimulus(input exp_t e);
    sb.push_back(e);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef PC_SEQ_EXC_EN
    exp_t ex;
`endif
    reset = 1'b0;
    pc = '0;
    imem_ready = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(mk("reset", RV, 1, 0, 0, 1, 0));
    reset = 1'b1;
    applyStimulus(mk("boot", RV, 1, 1, 0, 1, 0));

    pc = 32'h3000; imem_ready = 1'b1;
    applyStimulus(mk("seq0", 32'h3004, 1, 1, 1, 0, 1));
    pc = 32'h3004;
    applyStimulus(mk("seq1", 32'h3008, 1, 1, 1, 0, 1));

    pc = 32'h3010; br_taken = 1'b1; br_target = 32'h3100;
    applyStimulus(mk("branch", 32'h3100, 1, 1, 1, 0, 1));
    stall = 1'b1;
    applyStimulus(mk("br_stall", '0, 0, 0, 0, 0, 1));

    idle();
    pc = 32'h3020; imem_ready = 1'b0; jmp = 1'b1; jmp_target = 32'h3400;
    applyStimulus(mk("jmp_miss", '0, 0, 0, 1, 1, 1));
    idle();
    br_taken = 1'b1; br_target = 32'h5000;
    applyStimulus(mk("wait_bub1", '0, 0, 0, 1, 1, 1));
    idle();
    applyStimulus(mk("wait_bub2", '0, 0, 0, 1, 1, 1));
    imem_ready = 1'b1;
    applyStimulus(mk("wait_done", 32'h3400, 1, 1, 1, 0, 1));

    pc = 32'h3400; jr = 1'b1; jr_target = 32'h3800; jmp = 1'b1; jmp_target = 32'h3900;
    applyStimulus(mk("jr_prio", 32'h3800, 1, 1, 1, 0, 1));
    idle();
    pc = 32'hFFFF_FFFC;
    applyStimulus(mk("wrap", 32'h0000_0000, 1, 1, 1, 0, 1));

    pc = 32'h3040; imem_ready = 1'b0;
    applyStimulus(mk("miss_nopend", '0, 0, 0, 1, 1, 1));
    imem_ready = 1'b1;
    applyStimulus(mk("wait_seq", 32'h3044, 1, 1, 1, 0, 1));

    pc = 32'h3500; imem_ready = 1'b0; jmp = 1'b1; jmp_target = 32'h3600;
    applyStimulus(mk("miss_pend", '0, 0, 0, 1, 1, 1));
    idle();
    applyStimulus(mk("wait_pend", '0, 0, 0, 1, 1, 1));
    reset = 1'b0;
    applyStimulus(mk("reset_wait", RV, 1, 0, 0, 1, 0));
    reset = 1'b1;
    applyStimulus(mk("reboot", RV, 1, 1, 0, 1, 0));
    pc = 32'h3000; imem_ready = 1'b1;
    applyStimulus(mk("no_stale_pend", 32'h3004, 1, 1, 1, 0, 1));

`ifdef PC_SEQ_EXC_EN
    pc = 32'h3020; stall = 1'b1; exc_req = 1'b1;
    applyStimulus(mk("exc", 32'h4180, 1, 1, 1, 1, 1));
    idle();
    pc = 32'h4180;
    ex = mk("exc_epc", 32'h4184, 1, 1, 1, 0, 1);
    ex.epc = 32'h3020; ex.chk_epc = 1'b1;
    applyStimulus(ex);
    pc = 32'h4184; eret = 1'b1;
    applyStimulus(mk("eret", 32'h3020, 1, 1, 1, 0, 1));
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
